sram_controller: RTL

Bus slave that converts single-word read/write requests from the CPU-side bus into asynchronous SRAM cycles on one 1M×32 chip. It sits behind the address decoder at the RAM address prefix: bus side is the slave end of the bus interface, chip side is the SRAM master interface. It uses a fixed-timing FSM with stall-based backpressure, and all chip-side outputs are registered.

---
 rtl/sram_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Bus slave turning single-word read/write requests into fixed-timing cycles on
// one 1Mx32 asynchronous SRAM. Chip-side controls are registered from next state.
module sram_controller #(
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_address,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_data_wr,
    input  logic [3:0]  bus_mask,
    output logic        bus_stall,
    output logic [31:0] bus_data_rd,
    output logic [31:0] bus_data_rd_2,
    output logic [19:0] sram_address,
    inout  logic [31:0] sram_data,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam int MAX_WAIT = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_PULSE - 1);

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          is_write, is_write_nx;
    logic [3:0]    mask_q, mask_nx;
    logic [31:0]   data_q;
    logic          drive_q;
    logic          ce_n_nx, oe_n_nx, we_n_nx, drive_nx;
    logic [3:0]    be_n_nx;
    logic          request;
    logic          unused_addr_bits;

    assign request          = bus_read | bus_write;
    assign unused_addr_bits = ^{bus_address[31:22], bus_address[1:0]};
    assign sram_data        = drive_q ? data_q : 'z;
    assign bus_data_rd_2    = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            is_write     <= 1'b0;
            mask_q       <= '0;
            data_q       <= '0;
            drive_q      <= 1'b0;
            sram_address <= '0;
            bus_data_rd  <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= '1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            is_write <= is_write_nx;
            mask_q   <= mask_nx;
            if (state == IDLE && bus_write)
                data_q <= bus_data_wr;
            if (state == IDLE && request)
                sram_address <= bus_address[21:2];
            if (state == READ && cnt == '0)
                bus_data_rd <= sram_data;
            drive_q   <= drive_nx;
            sram_ce_n <= ce_n_nx;
            sram_oe_n <= oe_n_nx;
            sram_we_n <= we_n_nx;
            sram_be_n <= be_n_nx;
        end
    end

    // Counter is reloaded on entry and the state is left when it reaches zero,
    // so it never wraps.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        is_write_nx = is_write;
        mask_nx     = mask_q;
        case (state)
            IDLE: begin
                if (bus_write) begin
                    state_nx    = WR_SETUP;
                    is_write_nx = 1'b1;
                    mask_nx     = bus_mask;
                end else if (bus_read) begin
                    state_nx    = READ;
                    cnt_nx      = RD_LOAD;
                    is_write_nx = 1'b0;
                end
            end
            READ: begin
                if (cnt == '0) state_nx = DONE;
                else           cnt_nx   = cnt - 1'b1;
            end
            WR_SETUP: begin
                state_nx = WR_PULSE;
                cnt_nx   = WR_LOAD;
            end
            WR_PULSE: begin
                if (cnt == '0) state_nx = DONE;
                else           cnt_nx   = cnt - 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ce_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        we_n_nx  = 1'b1;
        be_n_nx  = '1;
        drive_nx = 1'b0;
        case (state_nx)
            READ: begin
                ce_n_nx = 1'b0;
                oe_n_nx = 1'b0;
                be_n_nx = '0;
            end
            WR_SETUP: begin
                ce_n_nx  = 1'b0;
                be_n_nx  = ~mask_nx;
                drive_nx = 1'b1;
            end
            WR_PULSE: begin
                ce_n_nx  = 1'b0;
                we_n_nx  = 1'b0;
                be_n_nx  = ~mask_nx;
                drive_nx = 1'b1;
            end
            DONE: begin
                if (is_write_nx) begin
                    ce_n_nx  = 1'b0;
                    be_n_nx  = ~mask_nx;
                    drive_nx = 1'b1;
                end
            end
            default: ;
        endcase
        bus_stall = (state == IDLE && request) ||
                    (state == READ) || (state == WR_SETUP) || (state == WR_PULSE);
    end

endmodule
